// File: rtl/ufm_arbiter_pkg.sv
// Shared types and constants for the UFM read arbiter.
package ufm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    STREAM,
    FINISH
  } state_t;

  localparam int unsigned UFM_ADDR_W     = 11;
  localparam int unsigned UFM_PAGE_BYTES = 16;

endpackage

// File: rtl/ufm_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted req searching upward from ptr+1, with wrap.
module rr_picker
  import ufm_arbiter_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [PTR_W-1:0] win_idx,
  output logic             any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!any && req[idx]) begin
        win[idx] = 1'b1;
        win_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ufm_arbiter.sv
// Round-robin arbiter sharing one ufm_reader among NUM_REQ requesters, one page per grant.
// Optional read watchdog enabled by defining UFM_ARBITER_TIMEOUT_EN.
module ufm_arbiter
  import ufm_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = UFM_ADDR_W,
  parameter int unsigned PAGE_BYTES     = UFM_PAGE_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [7:0]                rd_data,
  output logic [NUM_REQ-1:0]        rd_stb,
  input  logic [NUM_REQ-1:0]        rd_stall,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      rdr_start,
  output logic [ADDR_W-1:0]         rdr_addr,
  output logic                      rdr_stall,
  input  logic [7:0]                rdr_data,
  input  logic                      rdr_data_stb,
  input  logic                      rdr_ready
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(PAGE_BYTES + 1);

  state_t               state, next_state;
  logic [NUM_REQ-1:0]   win;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     ptr;
  logic                 any_req;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 launch_ok;
  logic                 last_beat;
  logic                 abort;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any_req)
  );

  assign launch_ok = any_req && rdr_ready;
  assign last_beat = rdr_data_stb && (beat_cnt == CNT_W'(PAGE_BYTES - 1));

`ifdef UFM_ARBITER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timed_out;

  // timed_out carries the abort into FINISH so err lines up with done
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state != STREAM || rdr_data_stb) wd_cnt <= '0;
      else if (!rdr_stall)                 wd_cnt <= wd_cnt + 1'b1;
      if (abort)                 timed_out <= 1'b1;
      else if (state == FINISH)  timed_out <= 1'b0;
    end
  end

  assign abort = (state == STREAM) && !rdr_data_stb && !rdr_stall &&
                 (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch_ok) next_state = LAUNCH;
      LAUNCH:  next_state = STREAM;
      STREAM:  if (last_beat || abort) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rdr_start = (state == LAUNCH);
    done      = (state == FINISH) ? gnt : '0;
    rd_data   = rdr_data;
    rd_stb    = '0;
    rdr_stall = 1'b0;
    if (state == STREAM) begin
      rd_stb    = gnt & {NUM_REQ{rdr_data_stb}};
      rdr_stall = |(gnt & rd_stall);
    end
`ifdef UFM_ARBITER_TIMEOUT_EN
    err = timed_out && (state == FINISH);
`else
    err = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      rdr_addr <= '0;
      ptr      <= PTR_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch_ok) begin
            gnt      <= win;
            rdr_addr <= req_addr[win_idx*ADDR_W +: ADDR_W];
            ptr      <= win_idx;
          end
        end
        STREAM: begin
          if (rdr_data_stb) beat_cnt <= beat_cnt + 1'b1;
        end
        FINISH: begin
          gnt      <= '0;
          beat_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ufm_arbiter.sv
// Directed bench for ufm_arbiter with a behavioural ufm_reader model; timeout step needs UFM_ARBITER_TIMEOUT_EN.
module tb_ufm_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 11;
  localparam int unsigned PB = 16;
  localparam int unsigned TO = 20;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      gnt;
  logic [7:0]        rd_data;
  logic [N-1:0]      rd_stb;
  logic [N-1:0]      rd_stall;
  logic [N-1:0]      done;
  logic              err;
  logic              rdr_start;
  logic [AW-1:0]     rdr_addr;
  logic              rdr_stall;
  logic [7:0]        rdr_data;
  logic              rdr_data_stb;
  logic              rdr_ready;

  ufm_arbiter #(
    .NUM_REQ        (N),
    .ADDR_W         (AW),
    .PAGE_BYTES     (PB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_addr     (req_addr),
    .gnt          (gnt),
    .rd_data      (rd_data),
    .rd_stb       (rd_stb),
    .rd_stall     (rd_stall),
    .done         (done),
    .err          (err),
    .rdr_start    (rdr_start),
    .rdr_addr     (rdr_addr),
    .rdr_stall    (rdr_stall),
    .rdr_data     (rdr_data),
    .rdr_data_stb (rdr_data_stb),
    .rdr_ready    (rdr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reader model: acts on the falling edge, one byte per unstalled cycle, bytes = beat index.
  int   m_limit    = PB;
  bit   spur       = 1'b0;
  bit   hold_ready = 1'b0;
  logic m_busy;
  logic m_ready;
  int   m_idx;

  initial begin
    rdr_data     = '0;
    rdr_data_stb = 1'b0;
    rdr_ready    = 1'b1;
    m_busy       = 1'b0;
    m_ready      = 1'b1;
    m_idx        = 0;
    forever begin
      @(negedge clk);
      rdr_data_stb = 1'b0;
      if (rst || (|done)) begin
        m_busy  = 1'b0;
        m_ready = 1'b1;
      end else if (rdr_start) begin
        m_busy  = 1'b1;
        m_ready = 1'b0;
        m_idx   = 0;
      end else if (m_busy) begin
        if (m_idx >= int'(PB)) begin
          m_busy  = 1'b0;
          m_ready = 1'b1;
        end else if (m_idx < m_limit && !rdr_stall) begin
          rdr_data     = 8'(m_idx);
          rdr_data_stb = 1'b1;
          m_idx++;
        end
      end
      if (spur) begin
        rdr_data     = 8'hAA;
        rdr_data_stb = 1'b1;
      end
      rdr_ready = m_ready && !hold_ready;
    end
  end

  // Monitor: per-transaction beat/order/stall tallies, latched when done pulses.
  int cyc = 0, last_stb_cyc = 0;
  int cur_beats = 0, cur_berr = 0, cur_stall = 0;
  int lat_beats = 0, lat_berr = 0, lat_stall = 0, lat_gap = 0;
  int done_total = 0, err_total = 0, viol_total = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        cur_beats = 0;
        cur_berr  = 0;
        cur_stall = 0;
      end else begin
        if (|rd_stb) begin
          if (rdr_stall) viol_total++;
          if (rd_data !== 8'(cur_beats)) cur_berr++;
          cur_beats++;
          last_stb_cyc = cyc;
        end
        if (rdr_stall) cur_stall++;
        if (err) err_total++;
        if (|done) begin
          lat_beats = cur_beats;
          lat_berr  = cur_berr;
          lat_stall = cur_stall;
          lat_gap   = cyc - last_stb_cyc;
          done_total++;
          cur_beats = 0;
          cur_berr  = 0;
          cur_stall = 0;
        end
      end
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(output logic [N-1:0] d);
    d = '0;
    for (int i = 0; i < 400; i++) begin
      cyc1();
      if (|done) begin
        d = done;
        return;
      end
    end
  endtask

  logic [N-1:0] d;
  int           dt;

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_addr = {11'd5, 11'd2042};
    rd_stall = '0;
    cyc1();
    cyc1();
    chk("rst_gnt",   32'(gnt), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);
    chk("rst_start", 32'(rdr_start), 0);
    chk("rst_addr",  32'(rdr_addr), 0);
    chk("rst_stb",   32'(rd_stb), 0);
    chk("rst_stall", 32'(rdr_stall), 0);
    rst = 1'b0;

    // single requester
    req = 2'b01;
    cyc1();
    chk("s_gnt",   32'(gnt), 32'h1);
    chk("s_start", 32'(rdr_start), 1);
    chk("s_addr",  32'(rdr_addr), 2042);
    cyc1();
    chk("s_start_pulse", 32'(rdr_start), 0);
    chk("s_addr_hold",   32'(rdr_addr), 2042);
    wait_done(d);
    chk("s_done",  32'(d), 32'h1);
    chk("s_err",   32'(err), 0);
    req = 2'b00;
    settle();
    chk("s_beats", 32'(lat_beats), 16);
    chk("s_order", 32'(lat_berr), 0);
    cyc1();
    chk("s_gnt_clr",  32'(gnt), 0);
    chk("s_done_clr", 32'(done), 0);

    // contention after reset: 0 then 1 then 0, with a stall on requester 1
    rst = 1'b1;
    cyc1();
    rst = 1'b0;
    req = 2'b11;
    cyc1();
    chk("c1_gnt",  32'(gnt), 32'h1);
    chk("c1_addr", 32'(rdr_addr), 2042);
    wait_done(d);
    chk("c1_done", 32'(d), 32'h1);
    settle();
    chk("c1_beats", 32'(lat_beats), 16);
    cyc1();
    chk("c2_idle", 32'(gnt), 0);
    cyc1();
    chk("c2_gnt",   32'(gnt), 32'h2);
    chk("c2_addr",  32'(rdr_addr), 5);
    chk("c2_start", 32'(rdr_start), 1);
    cyc1();
    cyc1();
    cyc1();
    cyc1();
    rd_stall = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stall_on", 32'(rdr_stall), 1);
      cyc1();
    end
    rd_stall = 2'b00;
    #1;
    chk("bp_stall_off", 32'(rdr_stall), 0);
    wait_done(d);
    chk("c2_done", 32'(d), 32'h2);
    chk("c2_err",  32'(err), 0);
    settle();
    chk("bp_beats",  32'(lat_beats), 16);
    chk("bp_order",  32'(lat_berr), 0);
    chk("bp_cycles", 32'(lat_stall), 5);
    chk("bp_viol",   32'(viol_total), 0);
    cyc1();
    cyc1();
    chk("c3_gnt",  32'(gnt), 32'h1);
    chk("c3_addr", 32'(rdr_addr), 2042);
    req = 2'b01;

    // reset in the middle of requester 0's read
    for (int i = 0; i < 100; i++) begin
      cyc1();
      if (cur_beats >= 7) break;
    end
    chk("mr_reached", 32'(cur_beats >= 7), 1);
    dt  = done_total;
    rst = 1'b1;
    cyc1();
    chk("mr_gnt",   32'(gnt), 0);
    chk("mr_done",  32'(done), 0);
    chk("mr_start", 32'(rdr_start), 0);
    rst = 1'b0;
    cyc1();
    chk("mr_regnt",  32'(gnt), 32'h1);
    chk("mr_restart", 32'(rdr_start), 1);
    wait_done(d);
    chk("mr_fin_done", 32'(d), 32'h1);
    req = 2'b00;
    settle();
    chk("mr_beats",   32'(lat_beats), 16);
    chk("mr_order",   32'(lat_berr), 0);
    chk("mr_no_done", 32'(done_total), 32'(dt + 1));

    // spurious strobes in IDLE, then rdr_ready held low
    cyc1();
    spur       = 1'b1;
    hold_ready = 1'b1;
    settle();
    chk("sp_stb", 32'(rd_stb), 0);
    cyc1();
    settle();
    chk("sp_stb2", 32'(rd_stb), 0);
    chk("sp_gnt",  32'(gnt), 0);
    spur = 1'b0;
    req  = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cyc1();
      chk("nr_gnt", 32'(gnt), 0);
    end
    hold_ready = 1'b0;
    cyc1();
    chk("nr_gnt_late", 32'(gnt), 32'h1);
    chk("nr_start",    32'(rdr_start), 1);
    wait_done(d);
    chk("nr_done", 32'(d), 32'h1);
    req = 2'b00;
    settle();
    chk("nr_beats", 32'(lat_beats), 16);
    chk("nr_order", 32'(lat_berr), 0);

`ifdef UFM_ARBITER_TIMEOUT_EN
    // reader stalls after 4 bytes; abort after 20 idle cycles
    cyc1();
    m_limit = 4;
    req     = 2'b01;
    wait_done(d);
    chk("to_done", 32'(d), 32'h1);
    chk("to_err",  32'(err), 1);
    req = 2'b00;
    settle();
    chk("to_beats", 32'(lat_beats), 4);
    chk("to_gap",   32'(lat_gap), 21);
    cyc1();
    chk("to_idle_gnt", 32'(gnt), 0);
    chk("to_err_clr",  32'(err), 0);
    m_limit = PB;
    chk("to_err_count", 32'(err_total), 1);
`else
    chk("no_err_total", 32'(err_total), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
